// File: rtl/mult_accumulate.sv
// Sums K unsigned multiplier products into one result with a valid/ready handshake on both sides.
// Define MAC_SAT_EN to clamp the accumulator at all-ones instead of wrapping on overflow.
module mult_accumulate #(
    parameter int N  = 6,
    parameter int K  = 4,
    parameter int AW = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*N-1:0]      P,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*N+AW-1:0]   acc_out,
    output logic [7:0]          count,
    input  logic                clr
);
    localparam int AccW = 2*N + AW;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t          state;
    logic [AccW-1:0] acc;
    logic [AccW-1:0] p_ext;
    logic [AccW-1:0] sum;
    logic            last;

`ifdef MAC_SAT_EN
    logic [AccW:0]   wide;

    // Once clamped, any further addition carries out again, so the value stays at all-ones.
    always_comb begin
        p_ext = AccW'(P);
        wide  = {1'b0, acc} + {1'b0, p_ext};
        sum   = wide[AccW] ? '1 : wide[AccW-1:0];
        last  = (count == 8'(K - 1));
    end
`else
    always_comb begin
        p_ext = AccW'(P);
        sum   = acc + p_ext;
        last  = (count == 8'(K - 1));
    end
`endif

    assign acc_out = acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (clr) begin
                        acc   <= '0;
                        count <= '0;
                    end else if (in_valid) begin
                        acc   <= p_ext;
                        count <= 8'd1;
                        if (K == 1) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (clr) begin
                        acc   <= '0;
                        count <= '0;
                        state <= IDLE;
                    end else if (in_valid) begin
                        acc   <= sum;
                        count <= count + 8'd1;
                        if (last) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    // clr is deliberately ignored here so a finished result cannot be dropped.
                    if (out_ready) begin
                        state     <= IDLE;
                        count     <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_accumulate.sv
// Directed bench for mult_accumulate: K=4 and K=8 instances with hand-computed sums.
module tb_mult_accumulate;
    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, out_valid, out_ready, clr;
    logic [11:0] P;
    logic [13:0] acc_out;
    logic [7:0]  count;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, clr8;
    logic [11:0] P8;
    logic [13:0] acc_out8;
    logic [7:0]  count8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mult_accumulate #(.N(6), .K(4), .AW(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .P(P),
        .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
        .count(count), .clr(clr)
    );

    mult_accumulate #(.N(6), .K(8), .AW(2)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .P(P8),
        .out_valid(out_valid8), .out_ready(out_ready8), .acc_out(acc_out8),
        .count(count8), .clr(clr8)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [11:0] p);
        in_valid = 1'b1;
        P        = p;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        int          got, cyc, acc_cnt;
        logic        checked;
        logic [13:0] exp_sum;
        logic [5:0]  m, q;

        rst = 1'b1; in_valid = 0; out_ready = 0; clr = 0; P = '0;
        in_valid8 = 0; out_ready8 = 0; clr8 = 0; P8 = '0;
        #12;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_acc_out",   32'(acc_out), 0);
        check("rst_count",     32'(count), 0);
        rst = 1'b0;
        #3;
        check("rst_in_ready",  32'(in_ready), 1);
        step();

        // Back-to-back 10,20,30,40
        in_valid = 1; P = 12'd10; step();
        check("first_count", 32'(count), 1);
        P = 12'd20; step();
        P = 12'd30; step();
        check("third_out_valid", 32'(out_valid), 0);
        P = 12'd40; step();
        in_valid = 0;
        check("b2b_out_valid", 32'(out_valid), 1);
        check("b2b_acc",       32'(acc_out), 100);
        check("b2b_count",     32'(count), 4);
        check("b2b_in_ready",  32'(in_ready), 0);

        // Stall in HOLD with a product offered
        in_valid = 1; P = 12'd7; out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_acc",   32'(acc_out), 100);
            check("hold_count", 32'(count), 4);
        end
        check("hold_out_valid", 32'(out_valid), 1);
        in_valid = 0; out_ready = 1; step(); out_ready = 0;
        check("consume_out_valid", 32'(out_valid), 0);
        check("consume_count",     32'(count), 0);
        check("consume_in_ready",  32'(in_ready), 1);

        // clr beats a simultaneous acceptance
        push(12'd5); push(12'd6);
        check("pre_clr_count", 32'(count), 2);
        clr = 1; in_valid = 1; P = 12'd50; step();
        clr = 0; in_valid = 0;
        check("clr_count", 32'(count), 0);
        check("clr_acc",   32'(acc_out), 0);
        push(12'd1); push(12'd2); push(12'd3); push(12'd4);
        check("post_clr_valid", 32'(out_valid), 1);
        check("post_clr_acc",   32'(acc_out), 10);
        out_ready = 1; step(); out_ready = 0;

        // Async reset between edges mid-accumulation
        push(12'd9); push(12'd9);
        #2 rst = 1;
        #1;
        check("arst_count",     32'(count), 0);
        check("arst_acc",       32'(acc_out), 0);
        check("arst_out_valid", 32'(out_valid), 0);
        #1 rst = 0;
        step();
        push(12'd11); push(12'd22); push(12'd33); push(12'd44);
        check("after_rst_acc",   32'(acc_out), 110);
        check("after_rst_valid", 32'(out_valid), 1);
        out_ready = 1; step(); out_ready = 0;

        // K=8 overflow boundary
        in_valid8 = 1; P8 = 12'd4095;
        for (int i = 0; i < 8; i++) step();
        in_valid8 = 0;
        check("k8_valid", 32'(out_valid8), 1);
        check("k8_count", 32'(count8), 8);
`ifdef MAC_SAT_EN
        check("k8_sat_acc", 32'(acc_out8), 16383);
`else
        check("k8_wrap_acc", 32'(acc_out8), 16376);
`endif
        clr8 = 1; step(); clr8 = 0;
        check("hold_clr_valid", 32'(out_valid8), 1);
`ifdef MAC_SAT_EN
        check("hold_clr_acc", 32'(acc_out8), 16383);
`else
        check("hold_clr_acc", 32'(acc_out8), 16376);
`endif
        out_ready8 = 1; step(); out_ready8 = 0;
        check("k8_consume_count", 32'(count8), 0);

        // Random m*q products with random handshake gaps
        got = 0; cyc = 0; acc_cnt = 0; exp_sum = '0; checked = 0;
        while (got < 5 && cyc < 2000) begin
            if (out_valid && !checked) begin
                check("rand_acc", 32'(acc_out), 32'(exp_sum));
                checked = 1;
            end
            m = 6'($urandom_range(0, 63));
            q = 6'($urandom_range(0, 63));
            in_valid  = 1'($urandom_range(0, 1));
            P         = 12'(m) * 12'(q);
            out_ready = 1'($urandom_range(0, 1));
            if (in_valid && in_ready) begin
                exp_sum = exp_sum + 14'(P);
                acc_cnt++;
            end
            if (out_valid && out_ready) begin
                got++;
                exp_sum = '0; acc_cnt = 0; checked = 0;
            end
            step();
            cyc++;
        end
        in_valid = 0; out_ready = 0;
        check("rand_results", 32'(got), 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mult_accumulate.md
MULT_ACCUMULATE -- requirements
Module: mult_accumulate

Interface
REQ-001 Parameter N, default 6: operand width of the upstream N-bit multiplier; product width 2N.
REQ-002 Parameter K, default 4: number of products summed per result, legal range 1..255.
REQ-003 Parameter AW, default 2: accumulator guard bits; accumulator width is 2N+AW.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  P carries a product to accept.
REQ-007 in_ready  output  1  block can accept a product this cycle.
REQ-008 P  input  2N  unsigned product from the multiplier's P output.
REQ-009 out_valid  output  1  acc_out holds a completed sum.
REQ-010 out_ready  input  1  downstream accepts acc_out this cycle.
REQ-011 acc_out  output  2N+AW  completed unsigned sum of K products.
REQ-012 count  output  8  products accepted in the current accumulation.
REQ-013 clr  input  1  synchronous abort of the current accumulation.

Function
REQ-014 The block SHALL implement FSM states IDLE, ACCUM and HOLD.
REQ-015 A product SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-016 in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD.
REQ-017 In IDLE, an accepted product SHALL load the accumulator with P zero-extended, set count to 1, and go to ACCUM; if K=1 it SHALL go directly to HOLD.
REQ-018 In ACCUM, an accepted product SHALL add P to the accumulator and increment count.
REQ-019 When the accepted product is the K-th, the next state SHALL be HOLD, with the final sum registered on the same edge.
REQ-020 In HOLD, out_valid SHALL be 1, acc_out SHALL be stable, and count SHALL equal K.
REQ-021 A HOLD-state edge with out_ready=1 SHALL go to IDLE, clear count to 0 and deassert out_valid on the next cycle.
REQ-022 Latency SHALL be exactly one cycle from the K-th acceptance edge to out_valid=1.
REQ-023 Throughput SHALL be K products per K+1 cycles, because one bubble cycle is spent in HOLD.
REQ-024 in_valid with in_ready=0 SHALL be ignored; P SHALL NOT be sampled.
REQ-025 clr=1 in IDLE or ACCUM SHALL zero the accumulator and count and go to IDLE, taking priority over a simultaneous acceptance.
REQ-026 clr=1 in HOLD SHALL be ignored, so a completed result is never lost.
REQ-027 Without MAC_SAT_EN, the accumulator SHALL wrap modulo 2^(2N+AW) on overflow.
REQ-028 acc_out SHALL be driven from the accumulator register with no combinational path from P.

Reset
REQ-029 On rst=1 the FSM SHALL enter IDLE immediately, regardless of clk.
REQ-030 Reset values: accumulator 0, count 0, out_valid 0, acc_out 0, in_ready 1 once rst is 0.
REQ-031 Reset asserted mid-ACCUM or during HOLD SHALL discard the partial or pending sum.

Configuration
REQ-032 Macro MAC_SAT_EN SHALL select the overflow behaviour of the accumulator.
REQ-033 With MAC_SAT_EN defined, any sum exceeding 2^(2N+AW)-1 SHALL clamp to all-ones and stay clamped until the result is consumed, clr, or rst.
REQ-034 Without MAC_SAT_EN, the block SHALL wrap per REQ-027 and contain no saturation logic.

Verification
REQ-035 N=6, K=4: accept P=10, 20, 30, 40 back-to-back -> out_valid=1 one cycle after the 4th, acc_out=100, count=4, in_ready=0.
REQ-036 Hold out_ready=0 for 5 cycles in HOLD while driving in_valid=1, P=7 -> acc_out stays 100, no product accepted; out_ready=1 -> IDLE, count=0.
REQ-037 After accepting 2 products, pulse clr together with in_valid=1 -> count=0, state IDLE, the product is not accepted; the next 4 products form a fresh sum.
REQ-038 N=6, AW=2, K=8, P=4095 eight times -> without MAC_SAT_EN acc_out=(8*4095) mod 16384=16376; with MAC_SAT_EN acc_out=16383.
REQ-039 Assert rst asynchronously between clock edges mid-ACCUM -> outputs at their reset values before the next edge; the subsequent K=4 sum is correct.
REQ-040 Drive P from MultiplierNbit with random m, q and random in_valid/out_ready gaps -> every acc_out equals the sum of the four accepted m*q products.
